// File: rtl/mips_mem_resp_pkg.sv
// Shared types and constants for the MIPS memory responder.
// Optional random stall feature is enabled with MEM_RESP_RANDOM_WAIT_EN.
package mips_mem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int          DEF_DEPTH_WORDS = 1024;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'hBFC0_0000;
    localparam int          DEF_WAIT_CYCLES = 2;

    // x^8 + x^6 + x^5 + x^4 + 1, left-shifting Fibonacci form
    localparam logic [7:0]  LFSR_SEED = 8'hA5;
    localparam logic [7:0]  LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mips_mem_resp_lfsr.sv
// 8-bit LFSR supplying per-request stall counts; only instantiated
// when MEM_RESP_RANDOM_WAIT_EN is defined.
module mips_mem_resp_lfsr
    import mips_mem_resp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [7:0] value
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            value <= LFSR_SEED;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/mips_mem_responder.sv
// Avalon-style word memory slave with programmable stall, byte lanes and a
// sticky error flag. MEM_RESP_RANDOM_WAIT_EN selects LFSR-driven stall counts.
module mips_mem_responder
    import mips_mem_resp_pkg::*;
#(
    parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        error
);

    localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0] mem [DEPTH_WORDS];

    state_t           state, state_nx;
    logic [3:0]       cnt, cnt_nx;
    logic [3:0]       n;
    logic [32:0]      off;
    logic [IDX_W-1:0] req_idx;
    logic             request, req_err, accept;

    logic [31:0]      lat_addr, lat_wd;
    logic [IDX_W-1:0] lat_idx;
    logic [3:0]       lat_be;
    logic             lat_rd, lat_wr, lat_err;

    logic             load, set_err, commit;
    logic [IDX_W-1:0] c_idx;
    logic [3:0]       c_be;
    logic [31:0]      c_wd;

    // Addresses below BASE_ADDR wrap to huge offsets and fail the span test.
    assign off     = {1'b0, address} - {1'b0, BASE_ADDR};
    assign req_idx = off[IDX_W+1:2];
    assign request = read | write;
    assign req_err = (read & write) | (address[1:0] != 2'b00) | (off >= SPAN);
    assign accept  = (state == ST_IDLE) & request;

`ifdef MEM_RESP_RANDOM_WAIT_EN
    logic [7:0] lfsr_q;

    mips_mem_resp_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (accept),
        .value   (lfsr_q)
    );

    assign n = 4'(32'(lfsr_q) % (WAIT_CYCLES + 1));
`else
    assign n = 4'(WAIT_CYCLES);
`endif

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        waitrequest = 1'b0;
        readdata    = 32'd0;
        load        = 1'b0;
        set_err     = 1'b0;
        commit      = 1'b0;
        c_idx       = req_idx;
        c_be        = byteenable;
        c_wd        = writedata;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    set_err = req_err;
                    if (n == 4'd0) begin
                        if (!req_err) readdata = mem[req_idx];
                        commit = write & ~req_err;
                    end else begin
                        waitrequest = 1'b1;
                        load        = 1'b1;
                        cnt_nx      = n - 4'd1;
                        state_nx    = (n == 4'd1) ? ST_ACK : ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                waitrequest = 1'b1;
                cnt_nx      = cnt - 4'd1;
                if (cnt_nx == 4'd0) state_nx = ST_ACK;
                // The initiator must hold its request steady while stalled.
                if (address != lat_addr || read != lat_rd || write != lat_wr)
                    set_err = 1'b1;
            end
            ST_ACK: begin
                if (!lat_err) readdata = mem[lat_idx];
                commit   = lat_wr & ~lat_err;
                c_idx    = lat_idx;
                c_be     = lat_be;
                c_wd     = lat_wd;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            error    <= 1'b0;
            lat_addr <= 32'd0;
            lat_wd   <= 32'd0;
            lat_idx  <= '0;
            lat_be   <= 4'd0;
            lat_rd   <= 1'b0;
            lat_wr   <= 1'b0;
            lat_err  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (set_err) error <= 1'b1;
            if (load) begin
                lat_addr <= address;
                lat_wd   <= writedata;
                lat_idx  <= req_idx;
                lat_be   <= byteenable;
                lat_rd   <= read;
                lat_wr   <= write;
                lat_err  <= req_err;
            end
        end
    end

    // Storage is never reset; a reset edge suppresses any pending commit.
    always_ff @(posedge clk) begin
        if (reset && commit) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wd[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomized self-checking bench for mips_mem_responder (WAIT_CYCLES=2 and 0
// instances); follows MEM_RESP_RANDOM_WAIT_EN for the stall model.
module tb_mips_mem_responder;

    localparam logic [31:0] BASE = 32'hBFC0_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] address, writedata, readdata;
    logic        read, write, waitrequest, error;
    logic [3:0]  byteenable;

    logic [31:0] z_address, z_writedata, z_readdata;
    logic        z_read, z_write, z_waitrequest, z_error;
    logic [3:0]  z_byteenable;

    mips_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
        .waitrequest(waitrequest), .error(error)
    );

    mips_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset), .address(z_address), .read(z_read), .write(z_write),
        .byteenable(z_byteenable), .writedata(z_writedata), .readdata(z_readdata),
        .waitrequest(z_waitrequest), .error(z_error)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] ref_mem [int];
    bit          err_exp;
    logic [7:0]  lfsr_m;

    function automatic int exp_stalls();
`ifdef MEM_RESP_RANDOM_WAIT_EN
        return int'(lfsr_m) % 3;
`else
        return 2;
`endif
    endfunction

    function automatic void lfsr_step();
        lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    endfunction

    function automatic bit is_err(input bit r, input bit w, input logic [31:0] a);
        return (r && w) || (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 32'd4096);
    endfunction

    function automatic logic [31:0] ref_word(input int idx);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'hxxxx_xxxx;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        read = 1'b0; write = 1'b0; address = 32'd0; byteenable = 4'd0; writedata = 32'd0;
        z_read = 1'b0; z_write = 1'b0; z_address = 32'd0; z_byteenable = 4'd0; z_writedata = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        err_exp = 1'b0;
        lfsr_m  = 8'hA5;
    endtask

    // One transfer on the stalled instance; starts and ends just after a rising edge.
    task automatic xfer(input bit r, input bit w, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input string name,
                        output logic [31:0] rd_o, output int stalls);
        int n_exp, idx;
        bit e, done;
        logic [31:0] exp_rd, cur;
        n_exp = exp_stalls();
        e     = is_err(r, w, a);
        idx   = int'((a - BASE) >> 2);
        exp_rd = e ? 32'd0 : ref_word(idx);
        read = r; write = w; address = a; byteenable = be; writedata = wd;
        stalls = 0; done = 1'b0; rd_o = 32'd0;
        while (!done && stalls <= 20) begin
            @(negedge clk);
            if (!waitrequest) begin
                done = 1'b1;
                rd_o = readdata;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        read = 1'b0; write = 1'b0;
        lfsr_step();
        if (e) begin
            err_exp = 1'b1;
        end else if (w) begin
            cur = ref_word(idx);
            for (int i = 0; i < 4; i++) if (be[i]) cur[8*i +: 8] = wd[8*i +: 8];
            ref_mem[idx] = cur;
        end
        checks++;
        if (!done || stalls != n_exp) begin
            failures++;
            $display("FAIL %s stalls: got %0d (done=%0d) expected %0d", name, stalls, done, n_exp);
        end
        if (r && !w) begin
            checks++;
            if (rd_o !== exp_rd) begin
                failures++;
                $display("FAIL %s readdata: got %h expected %h", name, rd_o, exp_rd);
            end
        end
        checks++;
        if (error !== err_exp) begin
            failures++;
            $display("FAIL %s error: got %b expected %b", name, error, err_exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks += 5;
        if (waitrequest !== 1'b0) begin failures++; $display("FAIL reset waitrequest: got %b expected 0", waitrequest); end
        if (readdata !== 32'd0)   begin failures++; $display("FAIL reset readdata: got %h expected 0", readdata); end
        if (error !== 1'b0)       begin failures++; $display("FAIL reset error: got %b expected 0", error); end
        if (z_waitrequest !== 1'b0) begin failures++; $display("FAIL reset z_waitrequest: got %b expected 0", z_waitrequest); end
        if (z_error !== 1'b0)     begin failures++; $display("FAIL reset z_error: got %b expected 0", z_error); end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; int st;
        xfer(0, 1, 32'hBFC0_0004, 4'hF, 32'h1234_5678, "wr_word", rd, st);
        xfer(1, 0, 32'hBFC0_0004, 4'h0, 32'd0, "rd_word", rd, st);
        checks++;
        if (rd !== 32'h1234_5678) begin failures++; $display("FAIL write_read value: got %h expected 12345678", rd); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; int st;
        xfer(0, 1, 32'hBFC0_0004, 4'b0010, 32'hAABB_CCDD, "wr_lane1", rd, st);
        xfer(1, 0, 32'hBFC0_0004, 4'h0, 32'd0, "rd_lane1", rd, st);
        checks++;
        if (rd !== 32'h1234_CC78) begin failures++; $display("FAIL byte_lanes value: got %h expected 1234cc78", rd); end
    endtask

    task automatic test_idle();
        @(negedge clk);
        checks += 2;
        if (waitrequest !== 1'b0) begin failures++; $display("FAIL idle waitrequest: got %b expected 0", waitrequest); end
        if (readdata !== 32'd0)   begin failures++; $display("FAIL idle readdata: got %h expected 0", readdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] rd; int st, idx;
        for (int i = 0; i < 16; i++)
            xfer(0, 1, BASE + 32'(i * 4), 4'hF, $urandom, "rnd_init", rd, st);
        for (int i = 0; i < 24; i++) begin
            idx = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1)
                xfer(1, 0, BASE + 32'(idx * 4), 4'($urandom), 32'd0, "rnd_rd", rd, st);
            else
                xfer(0, 1, BASE + 32'(idx * 4), 4'($urandom), $urandom, "rnd_wr", rd, st);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; int st;
        xfer(1, 0, 32'hBFC0_1000, 4'hF, 32'd0, "err_oob", rd, st);
        checks += 2;
        if (rd !== 32'd0)   begin failures++; $display("FAIL err_oob data: got %h expected 0", rd); end
        if (error !== 1'b1) begin failures++; $display("FAIL err_oob flag: got %b expected 1", error); end
        do_reset();
        xfer(1, 1, 32'hBFC0_0004, 4'hF, 32'hFFFF_FFFF, "err_rdwr", rd, st);
        xfer(1, 0, 32'hBFC0_0004, 4'h0, 32'd0, "err_rdwr_chk", rd, st);
        do_reset();
        xfer(1, 0, 32'hBFC0_0002, 4'hF, 32'd0, "err_misalign", rd, st);
        do_reset();
        xfer(1, 0, 32'hBFBF_FFFC, 4'hF, 32'd0, "err_below", rd, st);
        do_reset();
    endtask

    task automatic test_wait_change();
        int n_exp, stalls;
        bit done;
        logic [31:0] rd, exp_rd;
        n_exp = exp_stalls();
        if (n_exp >= 2) begin
            exp_rd = ref_word(1);
            read = 1'b1; address = 32'hBFC0_0004; byteenable = 4'hF;
            @(negedge clk);
            stalls = waitrequest ? 1 : 0;
            @(posedge clk); #1;
            address = 32'hBFC0_0008;
            done = 1'b0; rd = 32'd0;
            while (!done && stalls <= 20) begin
                @(negedge clk);
                if (!waitrequest) begin done = 1'b1; rd = readdata; end
                else stalls++;
                @(posedge clk); #1;
            end
            read = 1'b0;
            lfsr_step();
            checks += 3;
            if (!done || stalls != n_exp) begin failures++; $display("FAIL wait_change stalls: got %0d expected %0d", stalls, n_exp); end
            if (rd !== exp_rd)   begin failures++; $display("FAIL wait_change data: got %h expected %h", rd, exp_rd); end
            if (error !== 1'b1)  begin failures++; $display("FAIL wait_change error: got %b expected 1", error); end
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int st, n_exp;
        xfer(0, 1, 32'hBFC0_0008, 4'hF, 32'hCAFE_F00D, "rm_old", rd, st);
        n_exp = exp_stalls();
        write = 1'b1; address = 32'hBFC0_0008; byteenable = 4'hF; writedata = 32'h0BAD_BEEF;
        @(negedge clk);
        checks++;
        if (waitrequest !== (n_exp > 0)) begin failures++; $display("FAIL reset_mid stall: got %b expected %b", waitrequest, n_exp > 0); end
        @(posedge clk); #1;
        reset = 1'b0; write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        if (n_exp == 0) ref_mem[2] = 32'h0BAD_BEEF;
        err_exp = 1'b0; lfsr_m = 8'hA5;
        @(negedge clk);
        checks += 2;
        if (waitrequest !== 1'b0) begin failures++; $display("FAIL reset_mid idle waitrequest: got %b expected 0", waitrequest); end
        if (error !== 1'b0)       begin failures++; $display("FAIL reset_mid error: got %b expected 0", error); end
        @(posedge clk); #1;
        xfer(1, 0, 32'hBFC0_0008, 4'h0, 32'd0, "rm_read", rd, st);
    endtask

    task automatic test_zero_wait();
        logic [31:0] vals [2];
        vals[0] = $urandom; vals[1] = $urandom;
        for (int i = 0; i < 4; i++) begin
            z_write = (i < 2); z_read = (i >= 2);
            z_address = BASE + 32'((i % 2) * 4); z_byteenable = 4'hF; z_writedata = vals[i % 2];
            @(negedge clk);
            checks++;
            if (z_waitrequest !== 1'b0) begin failures++; $display("FAIL zero_wait stall op%0d: got %b expected 0", i, z_waitrequest); end
            if (i >= 2) begin
                checks++;
                if (z_readdata !== vals[i % 2]) begin failures++; $display("FAIL zero_wait data op%0d: got %h expected %h", i, z_readdata, vals[i % 2]); end
            end
            @(posedge clk); #1;
        end
        z_read = 1'b0; z_write = 1'b0;
        @(negedge clk);
        checks += 2;
        if (z_readdata !== 32'd0) begin failures++; $display("FAIL zero_wait idle data: got %h expected 0", z_readdata); end
        if (z_error !== 1'b0)     begin failures++; $display("FAIL zero_wait error: got %b expected 0", z_error); end
        @(posedge clk); #1;
    endtask

    task automatic test_random_wait();
`ifdef MEM_RESP_RANDOM_WAIT_EN
        logic [31:0] rd; int st;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            xfer(1, 0, BASE + 32'(($urandom_range(0, 15)) * 4), 4'hF, 32'd0, "rwait_rd", rd, st);
            checks++;
            if (st > 2) begin failures++; $display("FAIL rwait range: got %0d expected 0..2", st); end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_idle();
        test_random();
        test_errors();
        test_wait_change();
        test_reset_mid();
        test_zero_wait();
        test_random_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
